// File: rtl/plic_lite.sv
// rtl/plic_lite.sv - lightweight interrupt controller; define PLIC_EDGE_TRIG_EN for edge-triggered gateways
module plic_lite #(
  parameter int NUM_SRC = 8,
  parameter int NUM_CTX = 2,
  parameter int PRIO_W  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_SRC-1:0]   src_irq,
  input  logic                 cfg_wen,
  input  logic [11:0]          cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  input  logic [NUM_CTX-1:0]   claim_req,
  output logic [NUM_CTX*5-1:0] claim_id,
  input  logic [NUM_CTX-1:0]   complete_req,
  input  logic [NUM_CTX*5-1:0] complete_id,
  output logic [NUM_CTX-1:0]   ext_int
);

  // All per-source vectors are indexed by source ID, so bit 0 ("none") never exists.
  logic [NUM_SRC:1]  src;
  logic [NUM_SRC:1]  pending_q;
  logic [NUM_SRC:1]  inflight_q;
  logic [NUM_SRC:1]  fire;
  logic [NUM_SRC:1]  done;
  logic [NUM_SRC:1]  claim_clr;
  logic [PRIO_W-1:0] prio_q   [1:NUM_SRC];
  logic [NUM_SRC:1]  enable_q [NUM_CTX];
  logic [PRIO_W-1:0] thr_q    [NUM_CTX];
  logic [4:0]        best     [NUM_CTX];
  logic [PRIO_W-1:0] best_p;
  logic              cfg_unused;

  assign src        = src_irq;
  assign cfg_unused = ^cfg_wdata;

`ifdef PLIC_EDGE_TRIG_EN
  logic [NUM_SRC:1] prev_q;
  logic [NUM_SRC:1] held_q;
  logic [NUM_SRC:1] rise;

  assign rise = src & ~prev_q;
  // An idle gateway fires on a fresh edge or on the one edge it remembered while in flight.
  assign fire = ~inflight_q & (rise | held_q);

  // Track the previous line level and remember at most one edge that arrives while in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
      held_q <= '0;
    end else begin
      prev_q <= src;
      held_q <= inflight_q & (held_q | rise);
    end
  end
`else
  // Level mode: an idle gateway fires whenever its line is high.
  assign fire = ~inflight_q & src;
`endif

  // Decode completions; out-of-range IDs never match and idle gateways are unaffected downstream
  always_comb begin
    done = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (complete_req[c] && complete_id[c*5 +: 5] == 5'(i)) done[i] = 1'b1;
      end
    end
  end

  // Per-context arbitration: strictly greater than the running best, so the lowest ID wins ties
  always_comb begin
    best_p = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      best[c] = '0;
      best_p  = thr_q[c];
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (pending_q[i] && enable_q[c][i] && prio_q[i] > best_p) begin
          best[c] = 5'(i);
          best_p  = prio_q[i];
        end
      end
    end
  end

  // Claims are granted in context order; a later context asking for a taken ID sees 0
  always_comb begin
    claim_clr = '0;
    claim_id  = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (claim_req[c] && !RST) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (best[c] == 5'(i) && !claim_clr[i]) begin
            claim_clr[i]        = 1'b1;
            claim_id[c*5 +: 5] = 5'(i);
          end
        end
      end
    end
  end

  // Gateway state and pending bits; a claim clears pending while a complete releases the gateway
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      pending_q  <= (pending_q & ~claim_clr) | fire;
      inflight_q <= (inflight_q & ~done) | fire;
    end
  end

  // Configuration writes land on the edge, so same-cycle arbitration sees the old values
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
      for (int c = 0; c < NUM_CTX; c++) begin
        enable_q[c] <= '0;
        thr_q[c]    <= '0;
      end
    end else if (cfg_wen) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (cfg_addr == 12'(4*i)) prio_q[i] <= cfg_wdata[PRIO_W-1:0];
      end
      for (int c = 0; c < NUM_CTX; c++) begin
        if (cfg_addr == 12'(256 + 4*c)) enable_q[c] <= cfg_wdata[NUM_SRC:1];
        if (cfg_addr == 12'(512 + 4*c)) thr_q[c]    <= cfg_wdata[PRIO_W-1:0];
      end
    end
  end

  // Interrupt request is the registered "something qualifies" flag per context
  always_ff @(posedge CLK) begin
    if (RST) begin
      ext_int <= '0;
    end else begin
      for (int c = 0; c < NUM_CTX; c++) ext_int[c] <= (best[c] != 5'd0);
    end
  end

  // Register readback; anything not decoded reads as zero
  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr == 12'h080) cfg_rdata = 32'({pending_q, 1'b0});
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (cfg_addr == 12'(4*i)) cfg_rdata = 32'(prio_q[i]);
    end
    for (int c = 0; c < NUM_CTX; c++) begin
      if (cfg_addr == 12'(256 + 4*c)) cfg_rdata = 32'({enable_q[c], 1'b0});
      if (cfg_addr == 12'(512 + 4*c)) cfg_rdata = 32'(thr_q[c]);
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// tb/tb_plic_lite.sv - self-checking bench for plic_lite with a behavioural reference model
module tb_plic_lite;
  localparam int NS = 8;
  localparam int NC = 2;
  localparam int PW = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NS-1:0]   src_irq;
  logic            cfg_wen;
  logic [11:0]     cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [31:0]     cfg_rdata;
  logic [NC-1:0]   claim_req;
  logic [NC*5-1:0] claim_id;
  logic [NC-1:0]   complete_req;
  logic [NC*5-1:0] complete_id;
  logic [NC-1:0]   ext_int;

  plic_lite #(.NUM_SRC(NS), .NUM_CTX(NC), .PRIO_W(PW)) dut (
    .CLK(CLK), .RST(RST), .src_irq(src_irq), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .claim_req(claim_req), .claim_id(claim_id),
    .complete_req(complete_req), .complete_id(complete_id), .ext_int(ext_int)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int m_prio[1:NS];
  int m_en[NC];
  int m_thr[NC];
  bit m_pend[1:NS];
  bit m_infl[1:NS];
  bit m_prev[1:NS];
  bit m_held[1:NS];
  bit m_ext[NC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit qualifies(int c, int id);
    return m_pend[id] && m_en[c][id] && m_prio[id] > m_thr[c];
  endfunction

  // Highest qualifying priority first, then the lowest ID carrying it
  function automatic int model_best(int c);
    int top = 0;
    for (int id = 1; id <= NS; id++)
      if (qualifies(c, id) && m_prio[id] > top) top = m_prio[id];
    if (top == 0) return 0;
    for (int id = 1; id <= NS; id++)
      if (qualifies(c, id) && m_prio[id] == top) return id;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    logic [31:0] r = 0;
    if (a == 12'h080) for (int id = 1; id <= NS; id++) r[id] = m_pend[id];
    for (int id = 1; id <= NS; id++) if (int'(a) == 4*id) r = m_prio[id];
    for (int c = 0; c < NC; c++) begin
      if (int'(a) == 256 + 4*c) r = m_en[c];
      if (int'(a) == 512 + 4*c) r = m_thr[c];
    end
    return r;
  endfunction

  // Check current outputs against the model, advance the model, then cross one clock edge
  task automatic tick();
    bit taken[1:NS];
    bit done_v[1:NS];
    bit fire_v[1:NS];
    int exp_claim[NC];
    bit ext_n[NC];
    int b, id;
    bit rise;
    #1;
    for (int i = 1; i <= NS; i++) begin taken[i] = 0; done_v[i] = 0; fire_v[i] = 0; end
    for (int c = 0; c < NC; c++) begin
      exp_claim[c] = 0;
      if (claim_req[c] && !RST) begin
        b = model_best(c);
        if (b != 0 && !taken[b]) begin exp_claim[c] = b; taken[b] = 1; end
      end
      check($sformatf("claim_id[%0d]", c), 32'(claim_id[c*5 +: 5]), 32'(exp_claim[c]));
      check($sformatf("ext_int[%0d]", c), 32'(ext_int[c]), 32'(m_ext[c]));
      ext_n[c] = (model_best(c) != 0);
    end
    check($sformatf("cfg_rdata@%0h", cfg_addr), cfg_rdata, model_read(cfg_addr));
    for (int c = 0; c < NC; c++) begin
      if (complete_req[c]) begin
        id = int'(complete_id[c*5 +: 5]);
        if (id >= 1 && id <= NS && m_infl[id]) done_v[id] = 1;
      end
    end
    for (int i = 1; i <= NS; i++) begin
`ifdef PLIC_EDGE_TRIG_EN
      rise = src_irq[i-1] && !m_prev[i];
      m_prev[i] = src_irq[i-1];
      if (m_infl[i]) begin
        if (rise) m_held[i] = 1;
      end else begin
        fire_v[i] = rise || m_held[i];
        m_held[i] = 0;
      end
`else
      rise = 0;
      fire_v[i] = !m_infl[i] && src_irq[i-1];
`endif
      m_pend[i] = (m_pend[i] && !taken[i]) || fire_v[i];
      m_infl[i] = (m_infl[i] && !done_v[i]) || fire_v[i];
    end
    if (cfg_wen) begin
      for (int i = 1; i <= NS; i++) if (int'(cfg_addr) == 4*i) m_prio[i] = int'(cfg_wdata) & ((1 << PW) - 1);
      for (int c = 0; c < NC; c++) begin
        if (int'(cfg_addr) == 256 + 4*c) m_en[c] = int'(cfg_wdata) & (((1 << NS) - 1) << 1);
        if (int'(cfg_addr) == 512 + 4*c) m_thr[c] = int'(cfg_wdata) & ((1 << PW) - 1);
      end
    end
    for (int c = 0; c < NC; c++) m_ext[c] = ext_n[c];
    if (RST) begin
      for (int i = 1; i <= NS; i++) begin
        m_prio[i] = 0; m_pend[i] = 0; m_infl[i] = 0; m_prev[i] = 0; m_held[i] = 0;
      end
      for (int c = 0; c < NC; c++) begin m_en[c] = 0; m_thr[c] = 0; m_ext[c] = 0; end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
    cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wen = 1'b0; cfg_addr = 12'h080; cfg_wdata = '0;
  endtask

  task automatic complete(input int c, input int id);
    complete_req = '0; complete_id = '0;
    complete_req[c] = 1'b1; complete_id[c*5 +: 5] = 5'(id);
    tick();
    complete_req = '0; complete_id = '0;
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 12'(4 * $urandom_range(0, NS + 1));
      1:       return 12'(256 + 4 * $urandom_range(0, NC));
      2:       return 12'(512 + 4 * $urandom_range(0, NC));
      3:       return 12'h080;
      default: return 12'(4 * $urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    RST = 1'b1; src_irq = '0; cfg_wen = 1'b0; cfg_addr = 12'h080; cfg_wdata = '0;
    claim_req = '0; complete_req = '0; complete_id = '0;
    @(negedge CLK);
    tick(); tick();
    #1; check("reset ext_int", 32'(ext_int), 32'h0);
    check("reset pending", cfg_rdata, 32'h0);
    RST = 1'b0;

    // Priority arbitration with a tie
    cfg_write(12'h00C, 2); cfg_write(12'h014, 2); cfg_write(12'h100, 32'h28); cfg_write(12'h200, 0);
    src_irq = 8'h14;
    tick();
    #1; check("arb pending", cfg_rdata, 32'h28);
    check("arb ext before latency", 32'(ext_int[0]), 32'h0);
    tick();
    #1; check("arb ext after latency", 32'(ext_int[0]), 32'h1);
    claim_req = 2'b01;
    #1; check("arb first claim", 32'(claim_id[4:0]), 32'd3);
    tick();
    claim_req = 2'b00;
    #1; check("arb ext held", 32'(ext_int[0]), 32'h1);
    tick();
    claim_req = 2'b01;
    #1; check("arb second claim", 32'(claim_id[4:0]), 32'd5);
    tick();
    claim_req = 2'b00; src_irq = '0;
    complete(0, 3); complete(0, 5);

    // Threshold gating on context 1
    cfg_write(12'h008, 4); cfg_write(12'h104, 32'h4); cfg_write(12'h204, 4);
    src_irq = 8'h02;
    tick(); tick(); tick();
    #1; check("thr blocks", 32'(ext_int[1]), 32'h0);
    cfg_write(12'h204, 3);
    #1; check("thr write latency", 32'(ext_int[1]), 32'h0);
    tick();
    #1; check("thr opens", 32'(ext_int[1]), 32'h1);
    claim_req = 2'b10;
    #1; check("thr claim", 32'(claim_id[9:5]), 32'd2);
    tick();
    claim_req = 2'b00; src_irq = '0;
    complete(1, 2);

    // Two contexts claiming the same source
    cfg_write(12'h204, 0); cfg_write(12'h004, 1); cfg_write(12'h100, 32'h2); cfg_write(12'h104, 32'h2);
    src_irq = 8'h01;
    tick();
    src_irq = 8'h00;
    tick();
    claim_req = 2'b11;
    #1; check("dual claim ctx0", 32'(claim_id[4:0]), 32'd1);
    check("dual claim ctx1", 32'(claim_id[9:5]), 32'd0);
    tick();
    claim_req = 2'b00;
    #1; check("dual pending cleared", cfg_rdata & 32'h2, 32'h0);
    complete(0, 1);

`ifdef PLIC_EDGE_TRIG_EN
    // Two edges during service collapse into one re-pend
    cfg_write(12'h018, 1); cfg_write(12'h100, 32'h40);
    src_irq = 8'h20; tick(); src_irq = 8'h00; tick();
    claim_req = 2'b01;
    #1; check("edge claim", 32'(claim_id[4:0]), 32'd6);
    tick();
    claim_req = 2'b00;
    src_irq = 8'h20; tick(); src_irq = 8'h00; tick();
    src_irq = 8'h20; tick(); src_irq = 8'h00; tick();
    complete(0, 6);
    #1; check("edge not yet re-pended", cfg_rdata & 32'h40, 32'h0);
    tick();
    #1; check("edge re-pend", cfg_rdata & 32'h40, 32'h40);
    claim_req = 2'b01; tick(); claim_req = 2'b00;
    complete(0, 6); tick(); tick();
    #1; check("edge single re-pend", cfg_rdata & 32'h40, 32'h0);
`else
    // Level source held high re-pends after completion; stray completes are ignored
    cfg_write(12'h010, 1); cfg_write(12'h100, 32'h10);
    src_irq = 8'h08; tick(); tick();
    claim_req = 2'b01;
    #1; check("level claim", 32'(claim_id[4:0]), 32'd4);
    tick();
    claim_req = 2'b00;
    complete(0, 4);
    #1; check("level not yet re-pended", cfg_rdata & 32'h10, 32'h0);
    tick();
    #1; check("level re-pend", cfg_rdata & 32'h10, 32'h10);
    src_irq = 8'h00;
    complete(0, 4);
    complete(0, 4);
    #1; check("idle complete ignored", cfg_rdata & 32'h10, 32'h10);
    claim_req = 2'b01; tick(); claim_req = 2'b00;
`endif

    // Reset in the middle of servicing source 2
    cfg_write(12'h008, 4); cfg_write(12'h100, 32'h4);
    src_irq = 8'h02; tick(); tick();
    RST = 1'b1; claim_req = 2'b11;
    tick();
    #1; check("rst ext_int", 32'(ext_int), 32'h0);
    check("rst claim_id", 32'(claim_id), 32'h0);
    tick();
    RST = 1'b0; claim_req = 2'b00;
    tick();
    #1; check("rst re-pend", cfg_rdata & 32'h4, 32'h4);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      RST = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) == 0) src_irq = NS'($urandom);
      cfg_wen = ($urandom_range(0, 3) == 0);
      cfg_addr = rand_addr();
      cfg_wdata = $urandom;
      claim_req = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      complete_req = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      for (int c = 0; c < NC; c++)
        complete_id[c*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(1, NS));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
